stack_ctrl: RTL and testbench
=============================

STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 12, width of stacked words.
REQ-002 Parameter ADDR_WIDTH, default 8, memory address width; depth = 2^ADDR_WIDTH.
REQ-003 clock  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 push_req  input  1  push request; requester holds it until push_ack.
REQ-006 push_data  input  DATA_WIDTH  word to push.
REQ-007 pop_req  input  1  pop request; requester holds it until pop_ack.
REQ-008 clear_err  input  1  clears the sticky error flags.
REQ-009 push_ack, pop_ack  output  1 each  combinational pulse in the accepting cycle.
REQ-010 ready  output  1  high when state is IDLE.
REQ-011 pop_valid  output  1  registered one-cycle strobe qualifying pop_data.
REQ-012 pop_data  output  DATA_WIDTH  registered popped word.
REQ-013 count  output  ADDR_WIDTH+1  occupancy (0..2^ADDR_WIDTH).
REQ-014 full, empty  output  1 each  count==2^ADDR_WIDTH, count==0.
REQ-015 overflow, underflow  output  1 each  sticky error flags.
REQ-016 mem_we  output  1;  mem_in_address, mem_out_address  output  ADDR_WIDTH;  mem_in_data  output  DATA_WIDTH;  mem_out_data  input  DATA_WIDTH  port to an external synchronous-read, 1-cycle-latency, read-before-write single-clock memory.

Function
REQ-017 The FSM SHALL have two states: IDLE and READ; IDLE->READ on pop accept, READ->IDLE unconditionally after one cycle.
REQ-018 In IDLE, pop_req && !empty SHALL be accepted: pop_ack=1, mem_out_address=count-1 (truncated), count decrements at the edge, state->READ.
REQ-019 In IDLE, push_req && !full && !pop_req SHALL be accepted: push_ack=1, mem_we=1, mem_in_address=count[ADDR_WIDTH-1:0], mem_in_data=push_data, count increments at the edge.
REQ-020 Simultaneous push_req and pop_req in IDLE with !empty: pop SHALL win; push not acked, no write.
REQ-021 In READ, push_req and pop_req SHALL be ignored (no ack, mem_we=0, count unchanged, no error flags set).
REQ-022 At the READ->IDLE edge pop_data SHALL capture mem_out_data and pop_valid SHALL be 1 for the following single cycle; latency pop_ack cycle -> pop_valid cycle = 2 cycles.
REQ-023 A new push or pop SHALL be acceptable in the same cycle pop_valid is high.
REQ-024 push_req while full in IDLE (pop_req low) SHALL set overflow; no write, count unchanged.
REQ-025 pop_req while empty in IDLE SHALL set underflow; no pop_valid; a push_req in the same cycle SHALL still be accepted.
REQ-026 clear_err SHALL clear both flags; a flag set event in the same cycle SHALL win over clear_err.
REQ-027 mem_we SHALL be 0 whenever no push is accepted; count SHALL never exceed 2^ADDR_WIDTH or wrap below 0.

Reset
REQ-028 reset_n low SHALL immediately force state=IDLE, count=0, pop_valid=0, pop_data=0, overflow=0, underflow=0; combinational outputs follow (ready=1, empty=1, full=0, mem_we=0).
REQ-029 Reset during READ SHALL abort the pop: no pop_valid after release; memory contents are logically discarded.

Structure
REQ-030 A shared package stack_pkg SHALL hold the state enum (IDLE, READ) and default width constants (12, 8).
REQ-031 stack_ctrl SHALL contain no sub-module; the memory is instantiated beside it in a stack_top wrapper.

Verification
REQ-032 Reset; push 0x123, push 0x456; pop, pop -> pop_data 0x456 then 0x123, each pop_valid 2 cycles after its pop_ack; count 2->0, empty=1.
REQ-033 256 pushes -> full=1, count=256; 257th push_req -> push_ack=0, mem_we=0, overflow=1, count=256.
REQ-034 pop_req when empty -> underflow=1, no pop_valid; clear_err with a new underflow -> still 1; clear_err alone -> 0.
REQ-035 count=1 with top 0x00F; push_req 0xABC and pop_req together -> pop_ack=1, push_ack=0, pop_data=0x00F, count=0.
REQ-036 push_req during the READ cycle -> ready=0, push_ack=0, mem_we=0; accepted on the next cycle.
REQ-037 reset_n low during READ -> pop_valid stays 0, count=0, ready=1 after release.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and default widths for the LIFO stack controller and its wrapper.
package stack_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_ADDR_WIDTH = 8;

endpackage

// File: rtl/stack_mem.sv
// Single-clock stack storage: synchronous read with one cycle of latency, read-before-write.
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] in_address,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ADDR_WIDTH-1:0] out_address,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] mem_r [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] out_data_r;

  // Array write and registered read; the read sees the value from before any same-cycle write.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_r[in_address] <= in_data;
    end
    out_data_r <= mem_r[out_address];
  end

  assign out_data = out_data_r;

endmodule

// File: rtl/stack_top.sv
// Stack wrapper: the controller with its storage placed beside it.
module stack_top
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push_req,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_req,
  input  logic                  clear_err,
  output logic                  push_ack,
  output logic                  pop_ack,
  output logic                  ready,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
);

  logic                  mem_we_s;
  logic [ADDR_WIDTH-1:0] mem_in_address_s;
  logic [ADDR_WIDTH-1:0] mem_out_address_s;
  logic [DATA_WIDTH-1:0] mem_in_data_s;
  logic [DATA_WIDTH-1:0] mem_out_data_s;

  stack_ctrl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ctrl (
    .clock           (clock),
    .reset_n         (reset_n),
    .push_req        (push_req),
    .push_data       (push_data),
    .pop_req         (pop_req),
    .clear_err       (clear_err),
    .push_ack        (push_ack),
    .pop_ack         (pop_ack),
    .ready           (ready),
    .pop_valid       (pop_valid),
    .pop_data        (pop_data),
    .count           (count),
    .full            (full),
    .empty           (empty),
    .overflow        (overflow),
    .underflow       (underflow),
    .mem_we          (mem_we_s),
    .mem_in_address  (mem_in_address_s),
    .mem_out_address (mem_out_address_s),
    .mem_in_data     (mem_in_data_s),
    .mem_out_data    (mem_out_data_s)
  );

  stack_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clock       (clock),
    .we          (mem_we_s),
    .in_address  (mem_in_address_s),
    .in_data     (mem_in_data_s),
    .out_address (mem_out_address_s),
    .out_data    (mem_out_data_s)
  );

endmodule

// File: rtl/stack_ctrl.sv
// LIFO stack controller driving an external synchronous-read, read-before-write memory.
// Pops take two cycles to deliver data; pushes complete in their accepting cycle.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push_req,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_req,
  input  logic                  clear_err,
  output logic                  push_ack,
  output logic                  pop_ack,
  output logic                  ready,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_in_address,
  output logic [ADDR_WIDTH-1:0] mem_out_address,
  output logic [DATA_WIDTH-1:0] mem_in_data,
  input  logic [DATA_WIDTH-1:0] mem_out_data
);

  localparam logic [ADDR_WIDTH:0] ONE_C   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state_r;
  logic [ADDR_WIDTH:0]     count_r;
  logic                    pop_valid_r;
  logic [DATA_WIDTH-1:0]   pop_data_r;
  logic                    overflow_r;
  logic                    underflow_r;

  logic                    full_s;
  logic                    empty_s;
  logic                    push_acc_s;
  logic                    pop_acc_s;
  logic                    ovf_set_s;
  logic                    unf_set_s;
  logic [ADDR_WIDTH:0]     count_m1_s;

  assign full_s     = (count_r == DEPTH_C);
  assign empty_s    = (count_r == {(ADDR_WIDTH+1){1'b0}});
  assign count_m1_s = count_r - ONE_C;

  // Request arbitration: pop beats push, and nothing is taken while a read is in flight.
  always_comb begin
    pop_acc_s  = 1'b0;
    push_acc_s = 1'b0;
    ovf_set_s  = 1'b0;
    unf_set_s  = 1'b0;
    if (state_r == IDLE) begin
      if (pop_req && !empty_s) begin
        pop_acc_s = 1'b1;
      end else if (push_req && !full_s) begin
        push_acc_s = 1'b1;
      end else begin
        push_acc_s = 1'b0;
      end
      ovf_set_s = push_req && full_s && !pop_req;
      unf_set_s = pop_req && empty_s;
    end else begin
      pop_acc_s  = 1'b0;
      push_acc_s = 1'b0;
    end
  end

  assign push_ack        = push_acc_s;
  assign pop_ack         = pop_acc_s;
  assign mem_we          = push_acc_s;
  assign mem_in_address  = count_r[ADDR_WIDTH-1:0];
  assign mem_in_data     = push_data;
  assign mem_out_address = count_m1_s[ADDR_WIDTH-1:0];

  // Control FSM with occupancy and registered pop result; memory data lands during READ.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      count_r     <= {(ADDR_WIDTH+1){1'b0}};
      pop_valid_r <= 1'b0;
      pop_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      pop_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (pop_acc_s) begin
            state_r <= READ;
            count_r <= count_m1_s;
          end else if (push_acc_s) begin
            count_r <= count_r + ONE_C;
          end else begin
            count_r <= count_r;
          end
        end
        READ: begin
          state_r     <= IDLE;
          pop_data_r  <= mem_out_data;
          pop_valid_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Sticky error flags; a new error in the same cycle outranks clear_err.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clear_err) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (unf_set_s) begin
        underflow_r <= 1'b1;
      end else if (clear_err) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  assign ready     = (state_r == IDLE);
  assign pop_valid = pop_valid_r;
  assign pop_data  = pop_data_r;
  assign count     = count_r;
  assign full      = full_s;
  assign empty     = empty_s;
  assign overflow  = overflow_r;
  assign underflow = underflow_r;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with the stack storage attached; expected values are hand-derived.
module tb_stack_ctrl;
  import stack_pkg::*;

  localparam int DW = 12;
  localparam int AW = 8;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          push_req;
  logic [DW-1:0] push_data;
  logic          pop_req;
  logic          clear_err;
  logic          push_ack, pop_ack, ready, pop_valid;
  logic [DW-1:0] pop_data;
  logic [AW:0]   count;
  logic          full, empty, overflow, underflow;
  logic          mem_we;
  logic [AW-1:0] mem_in_address, mem_out_address;
  logic [DW-1:0] mem_in_data, mem_out_data;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  stack_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .push_req(push_req), .push_data(push_data),
    .pop_req(pop_req), .clear_err(clear_err), .push_ack(push_ack), .pop_ack(pop_ack),
    .ready(ready), .pop_valid(pop_valid), .pop_data(pop_data), .count(count),
    .full(full), .empty(empty), .overflow(overflow), .underflow(underflow),
    .mem_we(mem_we), .mem_in_address(mem_in_address), .mem_out_address(mem_out_address),
    .mem_in_data(mem_in_data), .mem_out_data(mem_out_data)
  );

  stack_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_mem (
    .clock(clock), .we(mem_we), .in_address(mem_in_address), .in_data(mem_in_data),
    .out_address(mem_out_address), .out_data(mem_out_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one word in IDLE: expect it acked and written at address wa.
  task automatic do_push(input logic [DW-1:0] d, input logic [AW-1:0] wa);
    push_req = 1'b1; push_data = d;
    #1;
    check("push_ack", 32'(push_ack), 32'd1);
    check("push_we", 32'(mem_we), 32'd1);
    check("push_waddr", 32'(mem_in_address), 32'(wa));
    check("push_wdata", 32'(mem_in_data), 32'(d));
    @(negedge clock);
    push_req = 1'b0;
  endtask

  // Pop with the stack non-empty; pop_valid two cycles after pop_ack, returning exp_d.
  task automatic do_pop(input logic [DW-1:0] exp_d, input logic [AW:0] exp_cnt);
    pop_req = 1'b1;
    #1;
    check("pop_ack", 32'(pop_ack), 32'd1);
    check("pop_raddr", 32'(mem_out_address), 32'(exp_cnt));
    @(negedge clock);
    pop_req = 1'b0;
    check("pop_read_ready", 32'(ready), 32'd0);
    check("pop_read_valid", 32'(pop_valid), 32'd0);
    check("pop_count", 32'(count), 32'(exp_cnt));
    @(negedge clock);
    check("pop_valid", 32'(pop_valid), 32'd1);
    check("pop_data", 32'(pop_data), 32'(exp_d));
  endtask

  initial begin
    reset_n = 1'b0; push_req = 1'b0; push_data = '0; pop_req = 1'b0; clear_err = 1'b0;
    @(negedge clock); @(negedge clock);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_valid", 32'(pop_valid), 32'd0);
    check("rst_data", 32'(pop_data), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_unf", 32'(underflow), 32'd0);
    reset_n = 1'b1;
    @(negedge clock);

    // Basic LIFO order, back-to-back pops
    do_push(12'h123, 8'd0);
    do_push(12'h456, 8'd1);
    check("cnt2", 32'(count), 32'd2);
    do_pop(12'h456, 9'd1);
    do_pop(12'h123, 9'd0);
    @(negedge clock);
    check("valid_one_cycle", 32'(pop_valid), 32'd0);
    check("cnt0", 32'(count), 32'd0);
    check("empty0", 32'(empty), 32'd1);

    // Underflow, and set beating clear
    pop_req = 1'b1;
    #1 check("unf_no_ack", 32'(pop_ack), 32'd0);
    @(negedge clock);
    pop_req = 1'b0;
    check("unf_set", 32'(underflow), 32'd1);
    check("unf_ready", 32'(ready), 32'd1);
    @(negedge clock);
    check("unf_no_valid", 32'(pop_valid), 32'd0);
    pop_req = 1'b1; clear_err = 1'b1;
    @(negedge clock);
    pop_req = 1'b0;
    check("unf_set_wins", 32'(underflow), 32'd1);
    @(negedge clock);
    clear_err = 1'b0;
    check("unf_cleared", 32'(underflow), 32'd0);

    // Pop on empty does not block a simultaneous push
    pop_req = 1'b1;
    do_push(12'h00F, 8'd0);
    pop_req = 1'b0;
    check("unf_push_unf", 32'(underflow), 32'd1);
    check("unf_push_cnt", 32'(count), 32'd1);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;

    // Simultaneous push and pop with one entry: pop wins
    push_req = 1'b1; push_data = 12'hABC; pop_req = 1'b1;
    #1;
    check("both_pop_ack", 32'(pop_ack), 32'd1);
    check("both_push_ack", 32'(push_ack), 32'd0);
    check("both_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    push_req = 1'b0; pop_req = 1'b0;
    @(negedge clock);
    check("both_data", 32'(pop_data), 32'h00F);
    check("both_valid", 32'(pop_valid), 32'd1);
    check("both_cnt", 32'(count), 32'd0);

    // Push held through the READ cycle is accepted afterwards
    do_push(12'h5A5, 8'd0);
    pop_req = 1'b1;
    #1 check("rd_pop_ack", 32'(pop_ack), 32'd1);
    @(negedge clock);
    pop_req = 1'b0; push_req = 1'b1; push_data = 12'h777;
    #1;
    check("rd_ready", 32'(ready), 32'd0);
    check("rd_push_ack", 32'(push_ack), 32'd0);
    check("rd_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    check("rd_valid", 32'(pop_valid), 32'd1);
    check("rd_data", 32'(pop_data), 32'h5A5);
    check("rd_ovf", 32'(overflow), 32'd0);
    do_push(12'h777, 8'd0);
    check("rd_cnt", 32'(count), 32'd1);

    // Reset during READ aborts the pop
    pop_req = 1'b1;
    @(negedge clock);
    pop_req = 1'b0;
    check("rst_rd_ready", 32'(ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("rst_rd_cnt", 32'(count), 32'd0);
    check("rst_rd_ready2", 32'(ready), 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    check("rst_rd_valid", 32'(pop_valid), 32'd0);
    @(negedge clock);
    check("rst_rd_valid2", 32'(pop_valid), 32'd0);
    check("rst_rd_empty", 32'(empty), 32'd1);

    // Fill to capacity, then overflow
    for (int i = 0; i < 256; i++) begin
      push_req = 1'b1; push_data = 12'(i);
      #1;
      if (push_ack !== 1'b1) check("fill_ack", 32'(push_ack), 32'd1);
      @(negedge clock);
    end
    push_req = 1'b0;
    check("full_flag", 32'(full), 32'd1);
    check("full_cnt", 32'(count), 32'd256);
    check("full_ovf0", 32'(overflow), 32'd0);
    push_req = 1'b1; push_data = 12'hFFF;
    #1;
    check("ovf_push_ack", 32'(push_ack), 32'd0);
    check("ovf_we", 32'(mem_we), 32'd0);
    @(negedge clock);
    push_req = 1'b0;
    check("ovf_set", 32'(overflow), 32'd1);
    check("ovf_cnt", 32'(count), 32'd256);
    do_pop(12'h0FF, 9'd255);
    check("after_full", 32'(full), 32'd0);
    clear_err = 1'b1;
    @(negedge clock);
    clear_err = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
